// File: rtl/loader_pkg.sv
// loader_pkg: shared state types and defaults for the UART ICCM loader
package loader_pkg;
  typedef enum logic {LOAD, RUN} ldr_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [31:0] END_MARKER_DEFAULT = 32'h0000_0FFF;
endpackage

// File: rtl/loader_uart_rx.sv
// loader_uart_rx: 8N1 receiver with synchroniser, start-glitch rejection and framing check
module loader_uart_rx
  import loader_pkg::*;
#(
  parameter int ClksPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx,
  input  logic       flush,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(ClksPerBit);
  localparam logic [CW-1:0] HALF = CW'(ClksPerBit / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(ClksPerBit - 1);
  logic [1:0] sync_q;
  logic rx_s;
  rx_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic stop_tick;
  assign rx_s = sync_q[1];
  assign stop_tick = state == RX_STOP && cnt == FULL && !flush;
  // Strobes are combinational so the top can register its write on the stop-sample edge
  assign byte_valid = stop_tick && rx_s;
  assign frame_err = stop_tick && !rx_s;
  assign byte_data = shift;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (flush) begin
        state <= RX_IDLE;
        cnt <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            cnt <= '0;
            if (!rx_s) state <= RX_START;
          end
          RX_START:
            if (cnt == HALF) begin
              cnt <= '0;
              bit_idx <= '0;
              state <= rx_s ? RX_IDLE : RX_DATA;
            end else cnt <= cnt + 1'b1;
          RX_DATA:
            if (cnt == FULL) begin
              cnt <= '0;
              shift <= {rx_s, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= RX_STOP;
            end else cnt <= cnt + 1'b1;
          RX_STOP:
            if (cnt == FULL) begin
              cnt <= '0;
              state <= RX_IDLE;
            end else cnt <= cnt + 1'b1;
          default: state <= RX_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/iccm_uart_loader.sv
// iccm_uart_loader: packs UART bytes into words, writes instruction memory, releases core on end marker
module iccm_uart_loader
  import loader_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 13,
  parameter int ClksPerBit = 16,
  parameter logic [DataWidth-1:0] EndMarker = DataWidth'(END_MARKER_DEFAULT),
  parameter bit LoadOnReset = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 uart_rx_i,
  input  logic                 load_req_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 core_rst_no,
  output logic                 done_o,
  output logic                 frame_err_o,
  output logic                 overflow_o
);
  localparam int NB = DataWidth / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  logic byte_valid, rx_ferr, word_last, done_q;
  logic [7:0] byte_data;
  ldr_state_e state;
  logic [BW-1:0] byte_cnt;
  logic [DataWidth-1:0] word, next_word;
  logic [AddrWidth-1:0] addr;
  loader_uart_rx #(.ClksPerBit(ClksPerBit)) u_rx (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rx(uart_rx_i),
    .flush(load_req_i),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(rx_ferr)
  );
  always_comb begin
    next_word = word;
    next_word[8*byte_cnt +: 8] = byte_data;
  end
  assign word_last = byte_cnt == BW'(NB - 1);
  assign core_rst_no = done_q;
  assign done_o = done_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= LoadOnReset ? LOAD : RUN;
      done_q <= !LoadOnReset;
      byte_cnt <= '0;
      word <= '0;
      addr <= '0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      frame_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      if (load_req_i) begin
        state <= LOAD;
        done_q <= 1'b0;
        byte_cnt <= '0;
        word <= '0;
        addr <= '0;
        frame_err_o <= 1'b0;
        overflow_o <= 1'b0;
      end else begin
        if (rx_ferr) frame_err_o <= 1'b1;
        if (byte_valid && state == LOAD) begin
          word <= word_last ? '0 : next_word;
          byte_cnt <= word_last ? '0 : byte_cnt + 1'b1;
          if (word_last) begin
            if (next_word == EndMarker) begin
              state <= RUN;
              done_q <= 1'b1;
            end else begin
              mem_we_o <= 1'b1;
              mem_addr_o <= addr;
              mem_wdata_o <= next_word;
              // The last address is written once, then loading stops instead of wrapping
              if (addr == '1) begin
                overflow_o <= 1'b1;
                state <= RUN;
                done_q <= 1'b1;
              end else addr <= addr + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_iccm_uart_loader.sv
// tb_iccm_uart_loader: randomized UART image loads checked against a byte-level loader model
module tb_iccm_uart_loader;
  localparam int CPB = 16, AW = 4, DW = 32;
  localparam logic [31:0] END_W = 32'h0000_0FFF;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, load_req = 1'b0;
  logic mem_we, core_rst_n, done, frame_err, overflow;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  int n_checks = 0, n_errors = 0;
  logic [AW-1:0] obs_addr[$], exp_addr[$];
  logic [DW-1:0] obs_data[$], exp_data[$];
  int m_addr, m_cnt;
  logic [31:0] m_word;
  bit m_run, m_ovf, m_ferr;

  iccm_uart_loader #(.DataWidth(DW), .AddrWidth(AW), .ClksPerBit(CPB), .LoadOnReset(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(uart_rx), .load_req_i(load_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .core_rst_no(core_rst_n), .done_o(done), .frame_err_o(frame_err), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && mem_we) begin
    obs_addr.push_back(mem_addr);
    obs_data.push_back(mem_wdata);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_clear();
    m_addr = 0; m_cnt = 0; m_word = '0; m_run = 0; m_ovf = 0; m_ferr = 0;
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_run) begin
      m_word[8*m_cnt +: 8] = b;
      m_cnt++;
      if (m_cnt == DW / 8) begin
        m_cnt = 0;
        if (m_word == END_W) m_run = 1;
        else begin
          exp_addr.push_back(AW'(m_addr));
          exp_data.push_back(m_word);
          if (m_addr == 2**AW - 1) begin m_ovf = 1; m_run = 1; end
          else m_addr++;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good = 1'b1);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx = good;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = 1'b1;
    if (good) model_byte(b);
    else begin
      m_ferr = 1;
      repeat (2 * CPB) @(posedge clk);
    end
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    return (w == END_W) ? ~w : w;
  endfunction

  task automatic pulse_load_req();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #23;
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_core_rst got %b want 0", core_rst_n); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_checks++; if ({frame_err, overflow} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b want 00", {frame_err, overflow}); end
    n_checks++; if ({mem_addr, mem_wdata} !== '0) begin n_errors++; $display("FAIL reset_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_hold_core got %b want 0", core_rst_n); end
  endtask

  task automatic test_load_basic();
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    for (int i = 0; i < 3; i++) send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_errors++; $display("FAIL basic_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++; if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin n_errors++; $display("FAIL basic_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    n_checks++; if ({core_rst_n, done} !== 2'b00) begin n_errors++; $display("FAIL basic_still_loading got %b want 00", {core_rst_n, done}); end
  endtask

  task automatic test_end_marker();
    send_word(END_W);
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_errors++; $display("FAIL end_no_write got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    n_checks++; if ({core_rst_n, done} !== {m_run, m_run}) begin n_errors++; $display("FAIL end_release got %b want %b", {core_rst_n, done}, {m_run, m_run}); end
    send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_errors++; $display("FAIL run_ignored got %0d want %0d", obs_addr.size(), exp_addr.size()); end
  endtask

  task automatic test_frame_err();
    pulse_load_req();
    @(negedge clk);
    n_checks++; if ({core_rst_n, done, frame_err} !== 3'b000) begin n_errors++; $display("FAIL reload_state got %b want 000", {core_rst_n, done, frame_err}); end
    send_byte(8'($urandom), 1'b0);
    send_word(32'hDDCC_BBAA);
    repeat (2) @(negedge clk);
    n_checks++; if (frame_err !== m_ferr) begin n_errors++; $display("FAIL ferr_flag got %b want %b", frame_err, m_ferr); end
    n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_errors++; $display("FAIL ferr_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++; if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin n_errors++; $display("FAIL ferr_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
  endtask

  task automatic test_overflow();
    pulse_load_req();
    for (int i = 0; i < 2**AW + 1; i++) send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_errors++; $display("FAIL ovf_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++; if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin n_errors++; $display("FAIL ovf_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    n_checks++; if ({overflow, done, core_rst_n} !== {m_ovf, m_run, m_run}) begin n_errors++; $display("FAIL ovf_flags got %b want %b", {overflow, done, core_rst_n}, {m_ovf, m_run, m_run}); end
  endtask

  task automatic test_load_req();
    pulse_load_req();
    @(negedge clk);
    n_checks++; if ({overflow, done, core_rst_n} !== 3'b000) begin n_errors++; $display("FAIL req_clear_ovf got %b want 000", {overflow, done, core_rst_n}); end
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL req_pre_ferr got %b want 1", frame_err); end
    pulse_load_req();
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL req_clear_ferr got %b want 0", frame_err); end
    send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != 1 || exp_addr.size() != 1) begin n_errors++; $display("FAIL req_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    else begin
      n_checks++; if ({obs_addr[0], obs_data[0]} !== {exp_addr[0], exp_data[0]}) begin n_errors++; $display("FAIL req_write got %h:%h want %h:%h", obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]); end
    end
  endtask

  task automatic test_glitch();
    pulse_load_req();
    @(posedge clk); #1 uart_rx = 1'b0;
    @(posedge clk); #1 uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_checks++; if (obs_addr.size() != 0) begin n_errors++; $display("FAIL glitch_write got %0d want 0", obs_addr.size()); end
    send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != 1) begin n_errors++; $display("FAIL glitch_count got %0d want 1", obs_addr.size()); end
    else begin
      n_checks++; if ({obs_addr[0], obs_data[0]} !== {exp_addr[0], exp_data[0]}) begin n_errors++; $display("FAIL glitch_write got %h:%h want %h:%h", obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]); end
    end
  endtask

  task automatic test_async_reset();
    send_word(rand_word());
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_we, done, core_rst_n, frame_err, overflow} !== 5'b0) begin n_errors++; $display("FAIL areset_outputs got %b want 00000", {mem_we, done, core_rst_n, frame_err, overflow}); end
    n_checks++; if ({mem_addr, mem_wdata} !== '0) begin n_errors++; $display("FAIL areset_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    send_word(rand_word());
    repeat (2) @(negedge clk);
    n_checks++; if (obs_addr.size() != 1) begin n_errors++; $display("FAIL areset_count got %0d want 1", obs_addr.size()); end
    else begin
      n_checks++; if ({obs_addr[0], obs_data[0]} !== {exp_addr[0], exp_data[0]}) begin n_errors++; $display("FAIL areset_write got %h:%h want %h:%h", obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_end_marker();
    test_frame_err();
    test_overflow();
    test_load_req();
    test_glitch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
